// File: rtl/hadamard_2d_ctrl_if.sv
// Handshake and engine bus for the 2D Hadamard controller.
// slave = controller side, master = row source / column sink / engine side.
interface hadamard_2d_ctrl_if #(
    parameter int W = 9
);
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_x0, in_x1, in_x2, in_x3;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_y0, out_y1, out_y2, out_y3;
    logic [1:0]          out_idx;
    logic                eng_en;
    logic signed [W-1:0] eng_x0, eng_x1, eng_x2, eng_x3;
    logic signed [W-1:0] eng_y0, eng_y1, eng_y2, eng_y3;
    logic                busy;

    modport slave (
        input  in_valid, in_x0, in_x1, in_x2, in_x3,
        input  out_ready,
        input  eng_y0, eng_y1, eng_y2, eng_y3,
        output in_ready,
        output out_valid, out_y0, out_y1, out_y2, out_y3, out_idx,
        output eng_en, eng_x0, eng_x1, eng_x2, eng_x3,
        output busy
    );

    modport master (
        output in_valid, in_x0, in_x1, in_x2, in_x3,
        output out_ready,
        output eng_y0, eng_y1, eng_y2, eng_y3,
        input  in_ready,
        input  out_valid, out_y0, out_y1, out_y2, out_y3, out_idx,
        input  eng_en, eng_x0, eng_x1, eng_x2, eng_x3,
        input  busy
    );
endinterface

// File: rtl/hadamard_2d_ctrl.sv
// 4x4 2D Hadamard sequencer: routes rows then columns through one shared pipelined
// 1D engine, tracking in-flight samples with a tag shift register matched to its latency.
//
// state  | meaning
// IDLE   | waiting for row 0; accepting it issues it to the engine immediately
// LOAD   | accepting rows 1..3, bubbles issued on empty cycles
// DRAIN1 | waiting for the last pass-1 results to land in r_buf
// COL    | issuing the 4 columns of r_buf to the engine
// DRAIN2 | waiting for the last pass-2 results to land in r_obuf
// OUT    | presenting output columns 0..3, engine frozen
module hadamard_2d_ctrl #(
    parameter int W       = 9,
    parameter int ENG_LAT = 6
) (
    input  logic              clk,
    input  logic              rst,
    hadamard_2d_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_DRAIN1 = 3'd2;
    localparam logic [2:0] S_COL    = 3'd3;
    localparam logic [2:0] S_DRAIN2 = 3'd4;
    localparam logic [2:0] S_OUT    = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         r_rows;
    logic [2:0]         r_cap;
    logic [1:0]         r_col;
    logic [1:0]         r_oidx;
    logic [ENG_LAT-1:0] r_tag;

    logic signed [W-1:0] r_buf  [4][4];
    logic signed [W-1:0] r_obuf [4][4];

    logic                w_in_ready;
    logic                w_accept;
    logic                w_eng_en;
    logic                w_tag_in;
    logic                w_capture;
    logic [2:0]          w_cap_nxt;
    logic                w_out_valid;
    logic signed [W-1:0] w_eng_x [4];

    assign w_in_ready = !rst && ((r_state == S_IDLE) ||
                                 ((r_state == S_LOAD) && (r_rows < 3'd4)));
    assign w_accept   = w_in_ready && bus.in_valid;

    // Row 0 is accepted while still in IDLE, so the engine must step on that cycle too.
    assign w_eng_en = (r_state == S_LOAD) || (r_state == S_DRAIN1) ||
                      (r_state == S_COL)  || (r_state == S_DRAIN2) ||
                      ((r_state == S_IDLE) && w_accept);

    assign w_tag_in    = w_accept || (r_state == S_COL);
    assign w_capture   = r_tag[ENG_LAT-1] && w_eng_en;
    assign w_cap_nxt   = r_cap + {2'b00, w_capture};
    assign w_out_valid = (r_state == S_OUT);

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_eng_x[k] = '0;
        end
        if (w_accept) begin
            w_eng_x[0] = bus.in_x0;
            w_eng_x[1] = bus.in_x1;
            w_eng_x[2] = bus.in_x2;
            w_eng_x[3] = bus.in_x3;
        end else if (r_state == S_COL) begin
            for (int k = 0; k < 4; k++) begin
                w_eng_x[k] = r_buf[k][r_col];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rows  <= 3'd0;
            r_cap   <= 3'd0;
            r_col   <= 2'd0;
            r_oidx  <= 2'd0;
            r_tag   <= '0;
        end else begin
            if (w_eng_en) begin
                for (int i = ENG_LAT-1; i > 0; i--) begin
                    r_tag[i] <= r_tag[i-1];
                end
                r_tag[0] <= w_tag_in;
            end
            r_cap <= w_cap_nxt;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rows  <= 3'd1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_rows <= r_rows + 3'd1;
                        if (r_rows == 3'd3) begin
                            r_state <= S_DRAIN1;
                        end
                    end
                end
                S_DRAIN1: begin
                    if (w_cap_nxt == 3'd4) begin
                        r_col   <= 2'd0;
                        r_state <= S_COL;
                    end
                end
                S_COL: begin
                    r_col <= r_col + 2'd1;
                    if (r_col == 2'd3) begin
                        r_state <= S_DRAIN2;
                    end
                end
                S_DRAIN2: begin
                    // capture counter wraps 7 -> 0 on the last pass-2 result
                    if ((r_cap == 3'd7) && w_capture) begin
                        r_oidx  <= 2'd0;
                        r_state <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        r_oidx <= r_oidx + 2'd1;
                        if (r_oidx == 2'd3) begin
                            r_rows  <= 3'd0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Captures 0..3 are pass-1 rows, 4..7 are pass-2 columns.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            if (!r_cap[2]) begin
                r_buf[r_cap[1:0]][0] <= bus.eng_y0;
                r_buf[r_cap[1:0]][1] <= bus.eng_y1;
                r_buf[r_cap[1:0]][2] <= bus.eng_y2;
                r_buf[r_cap[1:0]][3] <= bus.eng_y3;
            end else begin
                r_obuf[0][r_cap[1:0]] <= bus.eng_y0;
                r_obuf[1][r_cap[1:0]] <= bus.eng_y1;
                r_obuf[2][r_cap[1:0]] <= bus.eng_y2;
                r_obuf[3][r_cap[1:0]] <= bus.eng_y3;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_idx   = r_oidx;
    assign bus.out_y0    = w_out_valid ? r_obuf[0][r_oidx] : '0;
    assign bus.out_y1    = w_out_valid ? r_obuf[1][r_oidx] : '0;
    assign bus.out_y2    = w_out_valid ? r_obuf[2][r_oidx] : '0;
    assign bus.out_y3    = w_out_valid ? r_obuf[3][r_oidx] : '0;
    assign bus.eng_en    = w_eng_en;
    assign bus.eng_x0    = w_eng_x[0];
    assign bus.eng_x1    = w_eng_x[1];
    assign bus.eng_x2    = w_eng_x[2];
    assign bus.eng_x3    = w_eng_x[3];
    assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_hadamard_2d_ctrl.sv
// Bench for hadamard_2d_ctrl: behavioural pipelined 4-point engine plus a direct
// Y = H*X*H reference, with directed and randomised blocks.
module tb_hadamard_2d_ctrl;
    localparam int W       = 9;
    localparam int ENG_LAT = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   X [4][4];

    hadamard_2d_ctrl_if #(.W(W)) bus ();

    hadamard_2d_ctrl #(.W(W), .ENG_LAT(ENG_LAT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int hs(input int a, input int b);
        return ($countones(a & b) % 2 == 1) ? -1 : 1;
    endfunction

    function automatic int wrapw(input int v);
        logic signed [W-1:0] t;
        t = W'(v);
        return int'(t);
    endfunction

    // Engine model: natural-order Sylvester H4, ENG_LAT enabled stages.
    logic signed [W-1:0] eng_pipe [ENG_LAT][4];

    function automatic int eng_sum(input int i);
        int ex[4];
        int s;
        ex[0] = int'(bus.eng_x0);
        ex[1] = int'(bus.eng_x1);
        ex[2] = int'(bus.eng_x2);
        ex[3] = int'(bus.eng_x3);
        s = 0;
        for (int j = 0; j < 4; j++) s += hs(i, j) * ex[j];
        return s;
    endfunction

    always @(posedge clk) begin
        if (bus.eng_en) begin
            for (int s = ENG_LAT-1; s > 0; s--)
                for (int i = 0; i < 4; i++) eng_pipe[s][i] <= eng_pipe[s-1][i];
            for (int i = 0; i < 4; i++) eng_pipe[0][i] <= W'(eng_sum(i));
        end
    end

    assign bus.eng_y0 = eng_pipe[ENG_LAT-1][0];
    assign bus.eng_y1 = eng_pipe[ENG_LAT-1][1];
    assign bus.eng_y2 = eng_pipe[ENG_LAT-1][2];
    assign bus.eng_y3 = eng_pipe[ENG_LAT-1][3];

    function automatic int ref_y(input int i, input int j);
        int s = 0;
        for (int k = 0; k < 4; k++)
            for (int l = 0; l < 4; l++) s += hs(i, k) * X[k][l] * hs(l, j);
        return wrapw(s);
    endfunction

    function automatic int out_y(input int i);
        case (i)
            0: return int'(bus.out_y0);
            1: return int'(bus.out_y1);
            2: return int'(bus.out_y2);
            default: return int'(bus.out_y3);
        endcase
    endfunction

    task automatic check_val(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic drive_row(input int r);
        bus.in_x0 = W'(X[r][0]);
        bus.in_x1 = W'(X[r][1]);
        bus.in_x2 = W'(X[r][2]);
        bus.in_x3 = W'(X[r][3]);
    endtask

    task automatic fill_const(input int v);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) X[r][c] = v;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) X[r][c] = int'($urandom_range(0, 511)) - 256;
    endtask

    // Returns t0 = cyc value sampled in the cycle row 0 is accepted (cycle 0).
    task automatic load_rows(input int alt, output int t0, output bit ok);
        int r = 0;
        int guard = 0;
        bit ph = 1'b0;
        t0 = -1;
        while (r < 4 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (alt != 0 && ph) begin
                bus.in_valid = 1'b0;
                bus.in_x0 = '0; bus.in_x1 = '0; bus.in_x2 = '0; bus.in_x3 = '0;
            end else begin
                bus.in_valid = 1'b1;
                drive_row(r);
            end
            ph = ~ph;
            #1;
            if (bus.in_valid && bus.in_ready) begin
                if (r == 0) t0 = cyc;
                r++;
            end
        end
        ok = (r == 4);
        if (!ok) check_val("row_accept_timeout", r, 4);
    endtask

    task automatic collect(input int stall, input int timing, input int t0);
        int j = 0;
        int guard = 0;
        int first = -1;
        int stall_left = (stall != 0) ? 5 : 0;
        while (j < 4 && guard < 300) begin
            @(negedge clk);
            guard++;
            bus.in_valid  = 1'b0;
            bus.out_ready = (j == 1 && stall_left > 0) ? 1'b0 : 1'b1;
            #1;
            if (bus.out_valid) begin
                if (first < 0) begin
                    first = cyc;
                    if (timing != 0) check_val("first_valid_cycle", first - t0, 20);
                end
                if (timing != 0 && stall == 0) check_val("idx_cycle", cyc - t0, 20 + j);
                check_val("out_idx", int'(bus.out_idx), j);
                for (int i = 0; i < 4; i++)
                    check_val($sformatf("y%0d_col%0d", i, j), out_y(i), ref_y(i, j));
                if (!bus.out_ready) begin
                    stall_left--;
                    check_val("stall_eng_en", int'(bus.eng_en), 0);
                end else begin
                    j++;
                end
            end
        end
        if (j < 4) check_val("output_timeout", j, 4);
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        check_val("in_ready_after_block", int'(bus.in_ready), 1);
        check_val("busy_after_block", int'(bus.busy), 0);
    endtask

    task automatic run_block(input int alt, input int stall);
        int t0;
        bit ok;
        load_rows(alt, t0, ok);
        if (ok) collect(stall, (alt == 0) ? 1 : 0, t0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        int t0;
        int guard;
        int spurious;
        bit ok;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_x0 = '0; bus.in_x1 = '0; bus.in_x2 = '0; bus.in_x3 = '0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_val("rst_in_ready", int'(bus.in_ready), 0);
        check_val("rst_out_valid", int'(bus.out_valid), 0);
        check_val("rst_eng_en", int'(bus.eng_en), 0);
        check_val("rst_busy", int'(bus.busy), 0);
        check_val("rst_out_idx", int'(bus.out_idx), 0);
        check_val("rst_out_y0", out_y(0), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("in_ready_after_rst", int'(bus.in_ready), 1);

        // all ones, back-to-back, with cycle timing
        fill_const(1);
        run_block(0, 0);

        // impulse at X[0][0]
        fill_const(0);
        X[0][0] = 1;
        run_block(0, 0);

        // all 127: DC term wraps to -16
        fill_const(127);
        run_block(0, 0);

        // all ones, rows on alternate cycles
        fill_const(1);
        run_block(1, 0);

        // output stall of 5 cycles at out_idx=1
        fill_rand();
        run_block(0, 1);

        // reset pulse during COL abandons the block
        fill_rand();
        load_rows(0, t0, ok);
        guard = 0;
        do begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            guard++;
        end while ((cyc - t0) < 11 && guard < 50);
        check_val("busy_in_col", int'(bus.busy), 1);
        check_val("eng_en_in_col", int'(bus.eng_en), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("in_ready_after_mid_rst", int'(bus.in_ready), 1);
        check_val("busy_after_mid_rst", int'(bus.busy), 0);
        spurious = 0;
        repeat (30) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) spurious++;
        end
        check_val("no_spurious_out_valid", spurious, 0);
        fill_rand();
        run_block(0, 0);

        // randomised blocks
        for (int b = 0; b < 8; b++) begin
            fill_rand();
            run_block(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
